reset_seq_ctrl: RTL and testbench



---
 rtl/reset_seq_ctrl_pkg.sv | 24 ++
 rtl/reset_seq_ctrl_if.sv | 30 +++
 rtl/reset_seq_ctrl_sync_debounce.sv | 74 +++++++
 rtl/reset_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// reset_seq_pkg : shared state, cause encodings and helpers for the
//                 CPU reset sequencer.                    Rev 1.0
// ------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_POR       = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RUN       = 2'd2,
    S_SOFT      = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_seq_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// reset_seq_ctrl_if : raw board inputs and CPU-facing reset outputs
//                     of the reset sequencer.             Rev 1.0
// ------------------------------------------------------------------
interface reset_seq_ctrl_if;

  logic       soft_req_i;
  logic       pll_lock_a_i;
  logic       pll_lock_b_i;
  logic       cpu_resetn_o;
  logic       cpu_soft_resetn_o;
  logic       por_done_o;
  logic [1:0] rst_cause_o;
  logic [7:0] lock_loss_cnt_o;

  // master: board / environment side
  modport master (
    output soft_req_i, pll_lock_a_i, pll_lock_b_i,
    input  cpu_resetn_o, cpu_soft_resetn_o, por_done_o, rst_cause_o, lock_loss_cnt_o
  );

  // slave: the sequencer itself
  modport slave (
    input  soft_req_i, pll_lock_a_i, pll_lock_b_i,
    output cpu_resetn_o, cpu_soft_resetn_o, por_done_o, rst_cause_o, lock_loss_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/reset_seq_ctrl_sync_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_debounce : 2-flop synchroniser with optional level debounce
//                 and a one-cycle rising-edge pulse.      Rev 1.0
// ------------------------------------------------------------------
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic async_i,
  output logic      level_o,
  output logic      rise_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic prev_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= sync_q[1];
        end
      end

      assign level_o = sync_q[1];
      assign rise_o  = sync_q[1] & ~prev_q;
    end else begin : g_debounce
      localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

      logic [DB_W-1:0] db_cnt_q;
      logic            level_q;
      logic            rise_q;

      // Count consecutive cycles that disagree with the held level; any
      // agreeing cycle (a bounce) restarts the count from zero.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          db_cnt_q <= '0;
          level_q  <= 1'b0;
          rise_q   <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          if (sync_q[1] == level_q) begin
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q <= '0;
            level_q  <= sync_q[1];
            rise_q   <= sync_q[1];
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
      end

      assign level_o = level_q;
      assign rise_o  = rise_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// reset_seq_ctrl : POR hold, dual-PLL lock qualification and soft-reset
//                  pulse generation for the MCU CPU.       Rev 1.0
// ------------------------------------------------------------------
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES         = 40000000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DEBOUNCE_CYCLES    = 500000,
  parameter int unsigned SOFT_PULSE_CYCLES  = 64,
  parameter int unsigned CNT_W              = 26
) (
  input  wire logic       clock,
  input  wire logic       reset,
  reset_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PULSE_CYCLES - 1);

  logic w_lock_a;
  logic w_lock_b;
  logic w_lock_a_rise;
  logic w_lock_b_rise;
  logic w_btn_level;
  logic w_soft_pulse;
  logic w_lock;
  logic w_unused_rise;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock   (clock),
    .reset   (reset),
    .async_i (bus.soft_req_i),
    .level_o (w_btn_level),
    .rise_o  (w_soft_pulse)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(0)) u_lock_a (
    .clock   (clock),
    .reset   (reset),
    .async_i (bus.pll_lock_a_i),
    .level_o (w_lock_a),
    .rise_o  (w_lock_a_rise)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(0)) u_lock_b (
    .clock   (clock),
    .reset   (reset),
    .async_i (bus.pll_lock_b_i),
    .level_o (w_lock_b),
    .rise_o  (w_lock_b_rise)
  );

  assign w_lock        = w_lock_a & w_lock_b;
  assign w_unused_rise = w_lock_a_rise ^ w_lock_b_rise ^ w_btn_level;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic             por_done_q, por_done_d;
  logic             cpu_resetn_q;
  logic             cpu_soft_resetn_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    loss_cnt_d = loss_cnt_q;
    por_done_d = por_done_q;
    case (state_q)
      S_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d    = S_WAIT_LOCK;
          cnt_d      = '0;
          por_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (!w_lock) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN, S_SOFT: begin
        // Lock loss outranks everything, including an in-flight soft pulse.
        if (!w_lock) begin
          state_d    = S_WAIT_LOCK;
          cnt_d      = '0;
          cause_d    = CAUSE_LOCK;
          loss_cnt_d = sat_inc8(loss_cnt_q);
        end else if (state_q == S_RUN) begin
          if (w_soft_pulse) begin
            state_d = S_SOFT;
            cnt_d   = '0;
            cause_d = CAUSE_SOFT;
          end
        end else if (cnt_q == SOFT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_POR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= S_POR;
      cnt_q             <= '0;
      cause_q           <= CAUSE_POR;
      loss_cnt_q        <= 8'd0;
      por_done_q        <= 1'b0;
      cpu_resetn_q      <= 1'b0;
      cpu_soft_resetn_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      cause_q           <= cause_d;
      loss_cnt_q        <= loss_cnt_d;
      por_done_q        <= por_done_d;
      cpu_resetn_q      <= (state_d == S_RUN) || (state_d == S_SOFT);
      cpu_soft_resetn_q <= (state_d == S_RUN);
    end
  end

  assign bus.cpu_resetn_o      = cpu_resetn_q;
  assign bus.cpu_soft_resetn_o = cpu_soft_resetn_q;
  assign bus.por_done_o        = por_done_q;
  assign bus.rst_cause_o       = cause_q;
  assign bus.lock_loss_cnt_o   = loss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_reset_seq_ctrl : directed self-checking bench for reset_seq_ctrl
//                     with shortened sequence lengths.    Rev 1.0
// ------------------------------------------------------------------
module tb_reset_seq_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   edges = 0;

  reset_seq_ctrl_if bus();

  reset_seq_ctrl #(
    .POR_CYCLES         (16),
    .LOCK_STABLE_CYCLES (8),
    .DEBOUNCE_CYCLES    (4),
    .SOFT_PULSE_CYCLES  (5),
    .CNT_W              (26)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // After tick() returns, the outputs show the value for "cycle edges".
  task automatic tick();
    @(posedge clock);
    #1;
    edges++;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    edges = 0;
  endtask

  task automatic test_reset();
    bus.soft_req_i   = 1'b0;
    bus.pll_lock_a_i = 1'b1;
    bus.pll_lock_b_i = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({bus.cpu_resetn_o, bus.cpu_soft_resetn_o, bus.por_done_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outs: got %b expected 000",
               {bus.cpu_resetn_o, bus.cpu_soft_resetn_o, bus.por_done_o});
    end
    vectors++;
    if (bus.rst_cause_o !== 2'd0 || bus.lock_loss_cnt_o !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_status: got cause %0d cnt %0d expected 0 0",
               bus.rst_cause_o, bus.lock_loss_cnt_o);
    end
  endtask

  task automatic test_por_sequence();
    release_reset();
    for (int i = 0; i < 26; i++) begin
      tick();
      vectors++;
      if (bus.por_done_o !== (edges >= 16)) begin
        miscompares++;
        $display("FAIL por_done cycle %0d: got %b expected %b", edges, bus.por_done_o, edges >= 16);
      end
      vectors++;
      if (bus.cpu_resetn_o !== (edges >= 24) || bus.cpu_soft_resetn_o !== (edges >= 24)) begin
        miscompares++;
        $display("FAIL release cycle %0d: got %b%b expected %b", edges,
                 bus.cpu_resetn_o, bus.cpu_soft_resetn_o, edges >= 24);
      end
    end
    vectors++;
    if (bus.rst_cause_o !== 2'd0) begin
      miscompares++;
      $display("FAIL por_cause: got %0d expected 0", bus.rst_cause_o);
    end
  endtask

  task automatic test_late_lock();
    reset = 1'b1;
    bus.pll_lock_a_i = 1'b0;
    #20;
    release_reset();
    for (int i = 0; i < 45; i++) begin
      tick();
      if (edges == 30) bus.pll_lock_a_i = 1'b1;
      vectors++;
      if (bus.cpu_resetn_o !== (edges >= 40)) begin
        miscompares++;
        $display("FAIL late_lock cycle %0d: got %b expected %b", edges, bus.cpu_resetn_o, edges >= 40);
      end
    end
  endtask

  task automatic test_soft_press();
    int lows = 0;
    bus.soft_req_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 10) bus.soft_req_i = 1'b0;
      if (bus.cpu_soft_resetn_o === 1'b0) lows++;
      vectors++;
      if (bus.cpu_soft_resetn_o !== !(k >= 7 && k <= 11) || bus.cpu_resetn_o !== 1'b1) begin
        miscompares++;
        $display("FAIL soft_press k=%0d: got resetn %b soft %b expected 1 %b", k,
                 bus.cpu_resetn_o, bus.cpu_soft_resetn_o, !(k >= 7 && k <= 11));
      end
    end
    vectors++;
    if (lows != 5 || bus.rst_cause_o !== 2'd2) begin
      miscompares++;
      $display("FAIL soft_press_summary: got lows %0d cause %0d expected 5 2", lows, bus.rst_cause_o);
    end
  endtask

  task automatic test_glitch_bounce();
    int lows = 0;
    bus.soft_req_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) bus.soft_req_i = 1'b0;
      vectors++;
      if (bus.cpu_soft_resetn_o !== 1'b1) begin
        miscompares++;
        $display("FAIL glitch k=%0d: got soft %b expected 1", k, bus.cpu_soft_resetn_o);
      end
    end
    bus.soft_req_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 8)  bus.soft_req_i = 1'b0;
      if (k == 10) bus.soft_req_i = 1'b1;
      if (k == 20) bus.soft_req_i = 1'b0;
      if (bus.cpu_soft_resetn_o === 1'b0) lows++;
      vectors++;
      if (bus.cpu_soft_resetn_o !== !(k >= 7 && k <= 11)) begin
        miscompares++;
        $display("FAIL bounce k=%0d: got soft %b expected %b", k,
                 bus.cpu_soft_resetn_o, !(k >= 7 && k <= 11));
      end
    end
    vectors++;
    if (lows != 5) begin
      miscompares++;
      $display("FAIL bounce_pulses: got %0d low cycles expected 5", lows);
    end
  endtask

  task automatic test_lock_loss_priority();
    bus.soft_req_i = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 4)  bus.pll_lock_b_i = 1'b0;
      if (k == 5)  bus.pll_lock_b_i = 1'b1;
      if (k == 10) bus.soft_req_i   = 1'b0;
      vectors++;
      if (bus.cpu_resetn_o !== !(k >= 7 && k <= 14) ||
          bus.cpu_soft_resetn_o !== !(k >= 7 && k <= 14)) begin
        miscompares++;
        $display("FAIL lock_loss k=%0d: got %b%b expected %b", k,
                 bus.cpu_resetn_o, bus.cpu_soft_resetn_o, !(k >= 7 && k <= 14));
      end
    end
    vectors++;
    if (bus.rst_cause_o !== 2'd1 || bus.lock_loss_cnt_o !== 8'd1) begin
      miscompares++;
      $display("FAIL lock_loss_status: got cause %0d cnt %0d expected 1 1",
               bus.rst_cause_o, bus.lock_loss_cnt_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      bus.pll_lock_b_i = 1'b0;
      tick();
      bus.pll_lock_b_i = 1'b1;
      repeat (14) tick();
      if (i == 99) begin
        vectors++;
        if (bus.lock_loss_cnt_o !== 8'd101) begin
          miscompares++;
          $display("FAIL loss_cnt_mid: got %0d expected 101", bus.lock_loss_cnt_o);
        end
      end
    end
    vectors++;
    if (bus.lock_loss_cnt_o !== 8'd255 || bus.cpu_resetn_o !== 1'b1 || bus.rst_cause_o !== 2'd1) begin
      miscompares++;
      $display("FAIL loss_cnt_sat: got cnt %0d resetn %b cause %0d expected 255 1 1",
               bus.lock_loss_cnt_o, bus.cpu_resetn_o, bus.rst_cause_o);
    end
  endtask

  task automatic test_reset_in_soft();
    bus.soft_req_i = 1'b1;
    repeat (9) tick();
    vectors++;
    if (bus.cpu_soft_resetn_o !== 1'b0 || bus.cpu_resetn_o !== 1'b1) begin
      miscompares++;
      $display("FAIL in_soft: got %b%b expected 10", bus.cpu_resetn_o, bus.cpu_soft_resetn_o);
    end
    reset = 1'b1;
    bus.soft_req_i = 1'b0;
    #1;
    vectors++;
    if ({bus.cpu_resetn_o, bus.cpu_soft_resetn_o, bus.por_done_o} !== 3'b000 ||
        bus.rst_cause_o !== 2'd0 || bus.lock_loss_cnt_o !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: got outs %b cause %0d cnt %0d expected 000 0 0",
               {bus.cpu_resetn_o, bus.cpu_soft_resetn_o, bus.por_done_o},
               bus.rst_cause_o, bus.lock_loss_cnt_o);
    end
    release_reset();
    for (int i = 0; i < 26; i++) begin
      tick();
      vectors++;
      if (bus.por_done_o !== (edges >= 16) || bus.cpu_resetn_o !== (edges >= 24) ||
          bus.cpu_soft_resetn_o !== (edges >= 24)) begin
        miscompares++;
        $display("FAIL reseq cycle %0d: got por %b resetn %b soft %b", edges,
                 bus.por_done_o, bus.cpu_resetn_o, bus.cpu_soft_resetn_o);
      end
    end
    vectors++;
    if (bus.rst_cause_o !== 2'd0) begin
      miscompares++;
      $display("FAIL reseq_cause: got %0d expected 0", bus.rst_cause_o);
    end
  endtask

  initial begin
    test_reset();
    test_por_sequence();
    test_late_lock();
    test_soft_press();
    test_glitch_bounce();
    test_lock_loss_priority();
    test_saturation();
    test_reset_in_soft();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
